// File: rtl/hamming_secded_codec.sv
// Registered SECDED Hamming codec: encodes or decodes one word per accepted
// transaction, with a one-entry output register and saturating error counters.
module hamming_secded_codec #(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 8,
  localparam int P0     = $clog2(DATA_W + 1),
  localparam int P1     = $clog2(DATA_W + 1 + P0),
  localparam int P      = $clog2(DATA_W + 1 + P1),
  localparam int N      = DATA_W + P + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [N-1:0]     out_data,
  output logic [P-1:0]     out_syndrome,
  output logic             out_single,
  output logic             out_double,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam logic [P-1:0] MAX_POS = P'(N - 1);

  // Hamming position of data bit idx: the idx-th position that is not a power of two.
  function automatic int data_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 1; pos < N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == idx) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic logic [P-1:0] calc_syn(input logic [N-1:0] w);
    logic [P-1:0] s;
    s = '0;
    for (int pos = 1; pos < N; pos++) begin
      if (w[pos]) s = s ^ P'(pos);
    end
    return s;
  endfunction

  logic [N-1:0]      enc_raw;
  logic [N-1:0]      enc_word;
  logic [P-1:0]      enc_par;
  logic [P-1:0]      dec_syn;
  logic              dec_q;
  logic [N-1:0]      dec_fixed;
  logic [DATA_W-1:0] dec_data;
  logic              dec_single;
  logic              dec_double;
  logic              accept;

  logic             out_valid_q, out_valid_d;
  logic             out_mode_q, out_mode_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [P-1:0]     out_syndrome_q, out_syndrome_d;
  logic             out_single_q, out_single_d;
  logic             out_double_q, out_double_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  assign enc_raw[0] = 1'b0;

  for (genvar k = 0; k < P; k++) begin : g_par_slot
    localparam int PP = 1 << k;
    assign enc_raw[PP] = 1'b0;
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_data_map
    localparam int POS = data_pos(i);
    assign enc_raw[POS] = in_data[i];
    assign dec_data[i]  = dec_fixed[POS];
  end

  // With parity slots zeroed, the syndrome of the placed data is exactly the parity vector.
  always_comb begin
    enc_par  = calc_syn(enc_raw);
    enc_word = enc_raw;
    for (int k = 0; k < P; k++) begin
      enc_word[1 << k] = enc_par[k];
    end
    enc_word[0] = ^enc_word[N-1:1];
  end

  always_comb begin
    dec_syn    = calc_syn(in_data);
    dec_q      = ^in_data;
    dec_fixed  = in_data;
    dec_single = 1'b0;
    dec_double = 1'b0;
    if (dec_q) begin
      if (dec_syn > MAX_POS) begin
        dec_double = 1'b1;
      end else begin
        dec_single = 1'b1;
        if (dec_syn != '0) dec_fixed = in_data ^ (N'(1) << dec_syn);
      end
    end else if (dec_syn != '0) begin
      dec_double = 1'b1;
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_mode_d     = out_mode_q;
    out_data_d     = out_data_q;
    out_syndrome_d = out_syndrome_q;
    out_single_d   = out_single_q;
    out_double_d   = out_double_q;
    corr_cnt_d     = corr_cnt_q;
    uncorr_cnt_d   = uncorr_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_mode_d  = in_mode;
      if (in_mode) begin
        out_data_d     = N'(dec_data);
        out_syndrome_d = dec_syn;
        out_single_d   = dec_single;
        out_double_d   = dec_double;
      end else begin
        out_data_d     = enc_word;
        out_syndrome_d = '0;
        out_single_d   = 1'b0;
        out_double_d   = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A clear in the same cycle as a counted result wins.
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (accept && in_mode) begin
      if (dec_single && corr_cnt_q != '1)   corr_cnt_d   = corr_cnt_q + 1'b1;
      if (dec_double && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_mode_q     <= 1'b0;
      out_data_q     <= '0;
      out_syndrome_q <= '0;
      out_single_q   <= 1'b0;
      out_double_q   <= 1'b0;
      corr_cnt_q     <= '0;
      uncorr_cnt_q   <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_mode_q     <= out_mode_d;
      out_data_q     <= out_data_d;
      out_syndrome_q <= out_syndrome_d;
      out_single_q   <= out_single_d;
      out_double_q   <= out_double_d;
      corr_cnt_q     <= corr_cnt_d;
      uncorr_cnt_q   <= uncorr_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_mode     = out_mode_q;
  assign out_data     = out_data_q;
  assign out_syndrome = out_syndrome_q;
  assign out_single   = out_single_q;
  assign out_double   = out_double_q;
  assign corr_cnt     = corr_cnt_q;
  assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Scoreboard bench for hamming_secded_codec: a DATA_W=4/CNT_W=2 instance and a
// DATA_W=11 instance, each checked against a bench-side SECDED reference model.
module tb_hamming_secded_codec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sel = 1'b0;
  logic        in_mode = 1'b0;
  logic [15:0] din = '0;
  logic        out_ready = 1'b1;
  logic        cnt_clr4 = 1'b0;

  logic       rdy4, ov4, om4, sgl4, dbl4;
  logic [7:0] od4;
  logic [2:0] syn4;
  logic [1:0] cc4, uc4;

  logic        rdy11, ov11, om11, sgl11, dbl11;
  logic [15:0] od11;
  logic [3:0]  syn11;
  logic [7:0]  cc11, uc11;

  hamming_secded_codec #(.DATA_W(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && !sel), .in_ready(rdy4), .in_mode(in_mode), .in_data(din[7:0]),
    .out_valid(ov4), .out_ready(out_ready), .out_mode(om4), .out_data(od4),
    .out_syndrome(syn4), .out_single(sgl4), .out_double(dbl4),
    .cnt_clr(cnt_clr4), .corr_cnt(cc4), .uncorr_cnt(uc4)
  );

  hamming_secded_codec #(.DATA_W(11), .CNT_W(8)) u_dut11 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel), .in_ready(rdy11), .in_mode(in_mode), .in_data(din),
    .out_valid(ov11), .out_ready(out_ready), .out_mode(om11), .out_data(od11),
    .out_syndrome(syn11), .out_single(sgl11), .out_double(dbl11),
    .cnt_clr(1'b0), .corr_cnt(cc11), .uncorr_cnt(uc11)
  );

  typedef struct {
    logic        mode;
    logic [31:0] data;
    logic [7:0]  syn;
    logic        single;
    logic        dbl;
    int          corr;
    int          unc;
  } exp_t;

  exp_t q4[$];
  exp_t q11[$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int phase = 0;
  int c4 = 0, u4c = 0, c11 = 0, u11c = 0;

  // Reference model: code-word rules applied position by position with integers.
  function automatic int calc_p(input int dw);
    int p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic logic [31:0] m_encode(input int dw, input logic [31:0] d);
    int p = calc_p(dw);
    int n = dw + p + 1;
    int j = 0;
    logic [31:0] w = '0;
    logic par;
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos] = d[j];
        j++;
      end
    end
    for (int k = 0; k < p; k++) begin
      par = 1'b0;
      for (int pos = 1; pos < n; pos++)
        if (((pos >> k) & 1) == 1 && (pos & (pos - 1)) != 0) par = par ^ w[pos];
      w[1 << k] = par;
    end
    w[0] = ^w;
    return w;
  endfunction

  function automatic exp_t m_decode(input int dw, input logic [31:0] w_in);
    int p = calc_p(dw);
    int n = dw + p + 1;
    int s = 0;
    int j = 0;
    logic q = 1'b0;
    logic [31:0] w = w_in;
    exp_t e;
    for (int pos = 0; pos < n; pos++) begin
      q = q ^ w[pos];
      if (pos > 0 && w[pos]) s = s ^ pos;
    end
    e.mode = 1'b1; e.single = 1'b0; e.dbl = 1'b0; e.corr = 0; e.unc = 0;
    e.syn = 8'(s);
    if (q && s > n - 1) e.dbl = 1'b1;
    else if (q) begin
      e.single = 1'b1;
      if (s != 0) w[s] = ~w[s];
    end else if (s != 0) e.dbl = 1'b1;
    e.data = '0;
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        e.data[j] = w[pos];
        j++;
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] data, input int syn, input logic s, input logic d);
    exp_t e;
    e.mode = 1'b1; e.data = data; e.syn = 8'(syn); e.single = s; e.dbl = d; e.corr = 0; e.unc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Must be called just after a rising edge; returns just after the accept edge.
  task automatic applyStimulus(input bit inst, input bit mode, input logic [31:0] word,
                               input bit clr, input bit given_ok, input exp_t given);
    int   dw = inst ? 11 : 4;
    bit   acc = 0;
    exp_t e;
    if (given_ok) e = given;
    else if (mode) e = m_decode(dw, word);
    else e = mk(m_encode(dw, word), 0, 1'b0, 1'b0);
    e.mode = mode;
    sel = inst; in_mode = mode; din = word[15:0]; in_valid = 1'b1; cnt_clr4 = clr;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (inst ? rdy11 : rdy4) acc = 1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: got no in_ready expected in_ready=1 at %0t", $time);
    end else if (!inst) begin
      if (clr) begin c4 = 0; u4c = 0; end
      else begin
        if (e.single && c4 < 3) c4++;
        if (e.dbl && u4c < 3) u4c++;
      end
      e.corr = c4; e.unc = u4c;
      q4.push_back(e);
    end else begin
      if (e.single && c11 < 255) c11++;
      if (e.dbl && u11c < 255) u11c++;
      e.corr = c11; e.unc = u11c;
      q11.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cnt_clr4 = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int t = 0; t < 200 && !idle; t++) begin
      @(negedge clk);
      if (q4.size() == 0 && q11.size() == 0 && !ov4 && !ov11) idle = 1;
    end
    if (!idle) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout: got q4=%0d q11=%0d expected 0 0", q4.size(), q11.size());
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (phase == 0); phase = (phase + 1) % 3; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitors compare every presented result (including stalled cycles) to the queue head.
  always @(negedge clk) begin
    if (!rst && ov4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL u4_extra: got out_valid=1 expected no pending result at %0t", $time);
      end else begin
        exp_t e;
        e = q4[0];
        checkOutput("u4_mode", 32'(om4), 32'(e.mode));
        checkOutput("u4_data", 32'(od4), e.data);
        checkOutput("u4_syn", 32'(syn4), 32'(e.syn));
        checkOutput("u4_single", 32'(sgl4), 32'(e.single));
        checkOutput("u4_double", 32'(dbl4), 32'(e.dbl));
        checkOutput("u4_corr_cnt", 32'(cc4), e.corr);
        checkOutput("u4_uncorr_cnt", 32'(uc4), e.unc);
        if (out_ready) void'(q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov11) begin
      if (q11.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL u11_extra: got out_valid=1 expected no pending result at %0t", $time);
      end else begin
        exp_t e;
        e = q11[0];
        checkOutput("u11_mode", 32'(om11), 32'(e.mode));
        checkOutput("u11_data", 32'(od11), e.data);
        checkOutput("u11_syn", 32'(syn11), 32'(e.syn));
        checkOutput("u11_single", 32'(sgl11), 32'(e.single));
        checkOutput("u11_double", 32'(dbl11), 32'(e.dbl));
        checkOutput("u11_corr_cnt", 32'(cc11), e.corr);
        checkOutput("u11_uncorr_cnt", 32'(uc11), e.unc);
        if (out_ready) void'(q11.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid4"}, 32'(ov4), 0);
    checkOutput({tag, "_ready4"}, 32'(rdy4), 1);
    checkOutput({tag, "_mode4"}, 32'(om4), 0);
    checkOutput({tag, "_data4"}, 32'(od4), 0);
    checkOutput({tag, "_syn4"}, 32'(syn4), 0);
    checkOutput({tag, "_flags4"}, 32'({sgl4, dbl4}), 0);
    checkOutput({tag, "_cnt4"}, 32'({cc4, uc4}), 0);
    checkOutput({tag, "_valid11"}, 32'(ov11), 0);
    checkOutput({tag, "_ready11"}, 32'(rdy11), 1);
    checkOutput({tag, "_data11"}, 32'(od11), 0);
    checkOutput({tag, "_cnt11"}, 32'({cc11, uc11}), 0);
  endtask

  initial begin
    exp_t none;
    logic [31:0] w;
    int d, b;
    none = mk(0, 0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors on the DATA_W=4 instance.
    applyStimulus(0, 0, 32'h0B, 0, 1, mk(32'hAA, 0, 1'b0, 1'b0));
    applyStimulus(0, 1, 32'hAA, 0, 1, mk(32'hB, 0, 1'b0, 1'b0));
    applyStimulus(0, 1, 32'h8A, 0, 1, mk(32'hB, 5, 1'b1, 1'b0));
    applyStimulus(0, 1, 32'hAB, 0, 1, mk(32'hB, 0, 1'b1, 1'b0));
    applyStimulus(0, 1, 32'hCA, 0, 1, mk(32'hD, 3, 1'b0, 1'b1));

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 32'(i) | ($urandom_range(0, 15) << 4), 0, 0, none);
      w = m_encode(4, i) ^ (32'd1 << $urandom_range(0, 7));
      applyStimulus(0, 1, w, 0, 0, none);
    end

    // Saturation with a 2-bit counter, then clear colliding with a counted result.
    wait_idle();
    cnt_clr4 = 1'b1;
    @(posedge clk); #1;
    cnt_clr4 = 1'b0; c4 = 0; u4c = 0;
    @(negedge clk);
    checkOutput("clr_corr", 32'(cc4), 0);
    checkOutput("clr_uncorr", 32'(uc4), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h8A, 0, 1, mk(32'hB, 5, 1'b1, 1'b0));
    applyStimulus(0, 1, 32'h8A, 1, 1, mk(32'hB, 5, 1'b1, 1'b0));
    wait_idle();

    // Back-to-back stream under a 1,0,0 ready pattern.
    ready_mode = 1; phase = 0;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0) applyStimulus(0, 0, $urandom, 0, 0, none);
      else begin
        w = m_encode(4, $urandom_range(0, 15));
        for (int f = $urandom_range(0, 2); f > 0; f--) w = w ^ (32'd1 << $urandom_range(0, 7));
        applyStimulus(0, 1, w, 0, 0, none);
      end
    end
    wait_idle();

    // Mixed random traffic on both instances with random back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      b = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 0) applyStimulus(b[0], 0, $urandom, 0, 0, none);
      else applyStimulus(b[0], 1, b[0] ? 32'($urandom_range(0, 65535)) : 32'($urandom_range(0, 255)), 0, 0, none);
    end
    wait_idle();

    // Reset while a result is held under stall.
    ready_mode = 3;
    @(posedge clk); #1;
    applyStimulus(0, 1, 32'h8A, 0, 1, mk(32'hB, 5, 1'b1, 1'b0));
    @(negedge clk);
    checkOutput("stall_held_valid", 32'(ov4), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    q4.delete(); q11.delete();
    c4 = 0; u4c = 0; c11 = 0; u11c = 0;
    @(negedge clk);
    check_all_zero("midstall_rst");
    @(posedge clk); #1;
    rst = 1'b0; ready_mode = 0;

    // DATA_W=11 round trips: encode, flip one bit, decode back to the original.
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 2047);
      b = $urandom_range(0, 15);
      if (i % 5 == 0) applyStimulus(1, 0, 32'(d), 0, 0, none);
      w = m_encode(11, d) ^ (32'd1 << b);
      applyStimulus(1, 1, w, 0, 1, mk(32'(d), b, 1'b1, 1'b0));
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_secded_codec.md
# hamming_secded_codec

Parametrised, registered single-error-correct / double-error-detect (SECDED) Hamming codec carrying one encode or decode transaction per cycle under valid/ready flow control. Generalises the fixed 4-bit, 3-parity combinational encoder to any data width, and adds an overall-parity bit, decode with correction, and saturating error counters. Sits between a data producer and a storage or link stage; the same instance encodes on write and decodes on read, selected per transaction.

## Interface
- DATA_W, 4, data bits per word (≥ 2)
- CNT_W, 8, width of each error counter
- P (localparam), smallest integer with 2^P ≥ DATA_W+P+1; 3 for DATA_W=4
- N (localparam), DATA_W+P+1, code-word width; 8 for DATA_W=4

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  transaction offered
- in_ready  out  1  transaction accepted when in_valid && in_ready
- in_mode  in  1  0 = encode, 1 = decode
- in_data  in  N  encode: data in [DATA_W-1:0], upper bits ignored; decode: received code word
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_mode  out  1  mode of the held result
- out_data  out  N  encode: code word; decode: corrected data in [DATA_W-1:0], upper bits 0
- out_syndrome  out  P  decode syndrome; 0 for encode
- out_single  out  1  decode: single error detected and corrected
- out_double  out  1  decode: uncorrectable error
- cnt_clr  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  saturating count of out_single results
- uncorr_cnt  out  CNT_W  saturating count of out_double results

## Operation
- Code-word layout: bit index = Hamming position. Bit 0 = overall parity. Power-of-two positions 1,2,4,… hold parity bits. Remaining positions 3,5,6,7,9,… take data bits d0,d1,… in ascending order.
- Parity bit at position 2^k = XOR of all data bits whose position has bit k set. For DATA_W=4: P1=d0^d1^d3, P2=d0^d2^d3, P4=d1^d2^d3.
- Bit 0 = XOR of bits [N-1:1], so the whole word has even parity.
- Decode: S = XOR of the positions of all set bits in [N-1:1]; Q = XOR of all N bits.
  - Q=0, S=0: clean. Data extracted unchanged, single=double=0.
  - Q=1, S=0: bit 0 in error. Data unchanged, single=1.
  - Q=1, 1≤S≤N-1: flip bit S, then extract. single=1.
  - Q=1, S>N-1 (shortened codes only): double=1. Data extracted uncorrected.
  - Q=0, S≠0: double=1. Data extracted uncorrected.
- Output register is one entry. in_ready = !out_valid || out_ready (combinational).
- On accept, all out_* fields load together. Otherwise they hold stable while out_valid=1 and out_ready=0.
- Counters increment by 1 on the cycle a result loads with single/double set. They saturate at 2^CNT_W-1.
- cnt_clr has priority over an increment in the same cycle: counter → 0.

## Timing
- Latency: 1 cycle, accept edge to out_valid. Full throughput is 1 transaction/cycle while out_ready=1.
- Result is consumed and a new one accepted on the same edge: new value loads, out_valid stays 1.
- rst (sync, any cycle, including with a result held or mid-stall): next edge clears out_valid, out_mode, out_data, out_syndrome, out_single, out_double, corr_cnt and uncorr_cnt to 0. The pending transaction is dropped.
- in_ready is 1 during and after reset.
- in_data and in_mode are sampled only on the accept edge.

## Test plan
- Encode, DATA_W=4, in_data=0x0B → out_data=0xAA one cycle later; out_syndrome=0, single=double=0. Sweep all 16 data values against the P1/P2/P4 equations.
- Decode 0xAA → data 0xB, clean. Decode 0x8A (bit 5 flipped) → data 0xB, syndrome 5, single=1, corr_cnt+1. Decode 0xAB → data 0xB, syndrome 0, single=1.
- Decode 0xCA (bits 5,6 flipped) → syndrome 3, double=1, single=0, uncorr_cnt+1.
- Back-to-back stream of 10 words with out_ready toggling 1,0,0,1,…: no loss, no duplication, order preserved, out_* stable while stalled.
- Build with CNT_W=2 and decode 5 single-error words → corr_cnt 1,2,3,3,3. Assert cnt_clr together with a 6th single error → 0.
- Assert rst while out_valid=1 and out_ready=0 → next cycle all outputs 0 and in_ready=1. Then DATA_W=11 (N=16) random encode→flip-one-bit→decode round trips return the original data with single=1.
